// File: rtl/ct_code_lock_ctrl.sv
// Two-code lock controller: a CT1 code (0110) arms the lock, and a CT2 code (1011) must follow within TIMEOUT cycles to unlock.
// Latency: one cycle; every output is registered and reflects the inputs sampled at the previous rising edge.
// Backpressure: none; valid codes that arrive in OPEN or LOCKOUT are dropped, and alarm_clr_i only acts in LOCKOUT.
//
// Ports:
//   clk_i          system clock; all state changes on the rising edge
//   rst_i          synchronous active-high reset; overrides every other input
//   code_valid_i   code_i is presented this cycle
//   code_i[3:0]    code {a,b,c,d}; a = code_i[3]
//   alarm_clr_i    operator clear; leaves LOCKOUT for IDLE
//   unlock_o       high while in OPEN (exactly OPEN_CYCLES cycles)
//   alarm_o        high while in LOCKOUT
//   ct1_hit_o      1-cycle pulse when a 0110 code is accepted (IDLE or ARMED)
//   ct2_hit_o      1-cycle pulse when a 1011 code is accepted in ARMED
//   fail_cnt_o     consecutive-failure count, saturating at MAX_FAIL
//   state_o        IDLE=0, ARMED=1, OPEN=2, LOCKOUT=3
module ct_code_lock_ctrl #(
    parameter int TIMEOUT     = 8,
    parameter int MAX_FAIL    = 3,
    parameter int OPEN_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       code_valid_i,
    input  logic [3:0] code_i,
    input  logic       alarm_clr_i,
    output logic       unlock_o,
    output logic       alarm_o,
    output logic       ct1_hit_o,
    output logic       ct2_hit_o,
    output logic [3:0] fail_cnt_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_OPEN    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] OPEN_LAST  = 8'(OPEN_CYCLES - 1);
    localparam logic [3:0] FAIL_MAX   = 4'(MAX_FAIL);
    localparam logic [3:0] CODE_CT1   = 4'b0110;
    localparam logic [3:0] CODE_CT2   = 4'b1011;

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] open_q, open_d;
    logic [3:0] fail_q, fail_d;
    logic       ct1_q, ct1_d;
    logic       ct2_q, ct2_d;
    logic       unlock_q, alarm_q;
    logic       fail_evt;
    logic [3:0] fail_inc;

    // Count after a failure, saturating so it can never wrap past MAX_FAIL.
    assign fail_inc = (fail_q >= FAIL_MAX) ? FAIL_MAX : fail_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        open_d   = open_q;
        fail_d   = fail_q;
        ct1_d    = 1'b0;
        ct2_d    = 1'b0;
        fail_evt = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (code_valid_i) begin
                    if (code_i == CODE_CT1) begin
                        state_d = S_ARMED;
                        timer_d = 8'd0;
                        ct1_d   = 1'b1;
                    end else begin
                        fail_evt = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                // A valid code has priority over a timer that would expire in the same cycle.
                if (code_valid_i) begin
                    if (code_i == CODE_CT2) begin
                        state_d = S_OPEN;
                        open_d  = 8'd0;
                        fail_d  = 4'd0;
                        ct2_d   = 1'b1;
                    end else if (code_i == CODE_CT1) begin
                        timer_d = 8'd0;
                        ct1_d   = 1'b1;
                    end else begin
                        fail_evt = 1'b1;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    fail_evt = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_OPEN: begin
                if (open_q == OPEN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    open_d = open_q + 8'd1;
                end
            end
            S_LOCKOUT: begin
                if (alarm_clr_i) begin
                    state_d = S_IDLE;
                    fail_d  = 4'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fail_evt) begin
            fail_d  = fail_inc;
            state_d = (fail_inc == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            timer_q  <= 8'd0;
            open_q   <= 8'd0;
            fail_q   <= 4'd0;
            ct1_q    <= 1'b0;
            ct2_q    <= 1'b0;
            unlock_q <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            open_q   <= open_d;
            fail_q   <= fail_d;
            ct1_q    <= ct1_d;
            ct2_q    <= ct2_d;
            unlock_q <= (state_d == S_OPEN);
            alarm_q  <= (state_d == S_LOCKOUT);
        end
    end

    assign unlock_o   = unlock_q;
    assign alarm_o    = alarm_q;
    assign ct1_hit_o  = ct1_q;
    assign ct2_hit_o  = ct2_q;
    assign fail_cnt_o = fail_q;
    assign state_o    = state_q;

endmodule
